// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and widths for the memory port arbiter.
//   port_e        : identifies the fetch (PORT_IF) or load/store (PORT_LS) port
//   port_state_e  : per-port response FSM state
//   STARVE_W      : width of the fetch starvation counter
//   DATA_W        : memory data width (from `MEM_DATA_WIDTH, default 32)
// No ports (package).
// -----------------------------------------------------------------------------
`ifndef MEM_DATA_WIDTH
`define MEM_DATA_WIDTH 32
`endif
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 16
`endif

package mem_arb_pkg;
   typedef enum logic {
      PORT_IF = 1'b0,
      PORT_LS = 1'b1
   } port_e;

   typedef enum logic [1:0] {
      P_IDLE     = 2'd0,
      P_INFLIGHT = 2'd1,
      P_HELD     = 2'd2
   } port_state_e;

   localparam int STARVE_W = 4;
   localparam int DATA_W   = `MEM_DATA_WIDTH;
endpackage

// File: rtl/mem_rsp_hold.sv
// -----------------------------------------------------------------------------
// mem_rsp_hold
// One-entry response buffer plus the per-port access FSM.
//   clk, reset  : clock, synchronous active-low reset
//   grant       : this port issues an access to memory this cycle
//   rsp_ready   : consumer accepts the response this cycle
//   mem_rdata   : memory read data (valid the cycle after the access)
//   rsp_valid   : response available for this port
//   rsp_data    : response word (live memory data or held copy)
//   busy        : port has an outstanding access (in flight or held)
// -----------------------------------------------------------------------------
module mem_rsp_hold
   import mem_arb_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              grant,
   input  logic              rsp_ready,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic              busy
);
   port_state_e       state;
   logic              vld_p1;
   logic [DATA_W-1:0] hold_p1;

   // Stage p1: access issued last cycle, response in flight or held
   always_ff @(posedge clk) begin
      if (!reset) begin
         state  <= P_IDLE;
         vld_p1 <= 1'b0;
      end else if (grant) begin
         state  <= P_INFLIGHT;
         vld_p1 <= 1'b1;
      end else begin
         case (state)
            P_INFLIGHT: begin
               state  <= rsp_ready ? P_IDLE : P_HELD;
               vld_p1 <= !rsp_ready;
            end
            P_HELD: begin
               if (rsp_ready) begin
                  state  <= P_IDLE;
                  vld_p1 <= 1'b0;
               end
            end
            default: begin
               state  <= P_IDLE;
               vld_p1 <= 1'b0;
            end
         endcase
      end
   end

   // Memory data is only valid for one cycle, so a refused response is parked here.
   always_ff @(posedge clk) begin
      if (state == P_INFLIGHT && !rsp_ready)
         hold_p1 <= mem_rdata;
   end

   // Masking with reset keeps a discarded in-flight access from being seen during reset.
   assign rsp_valid = vld_p1 & reset;
   assign rsp_data  = (state == P_HELD) ? hold_p1 : mem_rdata;
   assign busy      = vld_p1;
endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port synchronous memory between instruction fetch
// (read-only) and load/store. At most one access per cycle; each response
// returns on its owner's port one cycle later, with a one-entry hold buffer
// per port so a stalled consumer never blocks the other port.
//   clk, reset                  : clock, synchronous active-low reset
//   if_req_*  / if_rsp_*        : fetch request / response handshake
//   ls_req_*  / ls_rsp_*        : load/store request / response handshake
//   mem_addr, mem_wdata, mem_rw : memory command (driven in the grant cycle)
//   mem_rdata                   : memory read data, one cycle after access
// Parameter STARVE_LIMIT: denied fetch cycles before fetch gets priority.
// Build option MEM_ARB_RR_EN: round-robin tie-break instead of load/store
// priority with starvation guard.
// -----------------------------------------------------------------------------
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req_valid,
   output logic              if_req_ready,
   input  logic [31:0]       if_req_addr,
   output logic              if_rsp_valid,
   input  logic              if_rsp_ready,
   output logic [DATA_W-1:0] if_rsp_data,
   input  logic              ls_req_valid,
   output logic              ls_req_ready,
   input  logic [31:0]       ls_req_addr,
   input  logic              ls_req_we,
   input  logic [DATA_W-1:0] ls_req_wdata,
   output logic              ls_rsp_valid,
   input  logic              ls_rsp_ready,
   output logic [DATA_W-1:0] ls_rsp_data,
   output logic [31:0]       mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_rw,
   input  logic [31:0]       mem_rdata
);
   logic              if_busy, ls_busy;
   logic              if_elig, ls_elig;
   logic              if_grant, ls_grant;
   logic [31:0]       addr_p1;
   logic [DATA_W-1:0] wdata_p1;

`ifdef MEM_ARB_RR_EN
   port_e rr_last;
`else
   localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);
   logic [STARVE_W-1:0] starve_cnt;

   function automatic logic [STARVE_W-1:0] sat_inc(input logic [STARVE_W-1:0] v);
      return (v >= LIMIT) ? LIMIT : v + 1'b1;
   endfunction
`endif

   // Stage p0: eligibility, grant and memory command in the same cycle
   // A port whose outstanding response is being accepted this cycle may issue again.
   assign if_elig = reset & if_req_valid & (!if_busy | if_rsp_ready);
   assign ls_elig = reset & ls_req_valid & (!ls_busy | ls_rsp_ready);

   always_comb begin
      if_grant = 1'b0;
      ls_grant = 1'b0;
      if (if_elig && ls_elig) begin
`ifdef MEM_ARB_RR_EN
         if (rr_last == PORT_LS) if_grant = 1'b1;
         else                    ls_grant = 1'b1;
`else
         if (starve_cnt == LIMIT) if_grant = 1'b1;
         else                     ls_grant = 1'b1;
`endif
      end else begin
         if_grant = if_elig;
         ls_grant = ls_elig;
      end
   end

   assign if_req_ready = if_grant;
   assign ls_req_ready = ls_grant;
   assign mem_rw       = ls_grant & ls_req_we;

   // Without a grant the command bus keeps its last value; reset forces zero,
   // which the p1 copy then inherits.
   always_comb begin
      mem_addr  = addr_p1;
      mem_wdata = wdata_p1;
      if (!reset) begin
         mem_addr  = '0;
         mem_wdata = '0;
      end else if (ls_grant) begin
         mem_addr  = ls_req_addr;
         mem_wdata = ls_req_wdata;
      end else if (if_grant) begin
         mem_addr  = if_req_addr;
      end
   end

   // Stage p1: last driven command, response tracking per port
   always_ff @(posedge clk) begin
      addr_p1  <= mem_addr;
      wdata_p1 <= mem_wdata;
   end

`ifdef MEM_ARB_RR_EN
   always_ff @(posedge clk) begin
      if (!reset)        rr_last <= PORT_IF;
      else if (if_grant) rr_last <= PORT_IF;
      else if (ls_grant) rr_last <= PORT_LS;
   end
`else
   always_ff @(posedge clk) begin
      if (!reset || !if_req_valid || if_grant) starve_cnt <= '0;
      else if (if_elig)                        starve_cnt <= sat_inc(starve_cnt);
   end
`endif

   mem_rsp_hold u_if_hold (
      .clk       (clk),
      .reset     (reset),
      .grant     (if_grant),
      .rsp_ready (if_rsp_ready),
      .mem_rdata (mem_rdata),
      .rsp_valid (if_rsp_valid),
      .rsp_data  (if_rsp_data),
      .busy      (if_busy)
   );

   mem_rsp_hold u_ls_hold (
      .clk       (clk),
      .reset     (reset),
      .grant     (ls_grant),
      .rsp_ready (ls_rsp_ready),
      .mem_rdata (mem_rdata),
      .rsp_valid (ls_rsp_valid),
      .rsp_data  (ls_rsp_data),
      .busy      (ls_busy)
   );
endmodule
